// File: rtl/usb_pkg.sv
// Shared encodings for the USB receive path: line states, sequencer states,
// error causes and the SYNC pattern.
package usb_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_ERROR = 3'd4
  } rx_state_t;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_SYNC_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_STUFF        = 3'd2;
  localparam logic [2:0] ERR_ALIGN        = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW     = 3'd4;
  localparam logic [2:0] ERR_SE1          = 3'd5;

  // Decoded bits shift in at the MSB, so the last eight wire bits 0000_0001 read back as this.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  function automatic logic nrzi_bit(input line_state_t cur, input line_state_t prev);
    return (cur == prev);
  endfunction

endpackage

// File: rtl/usb_bit_sampler.sv
// Synchronises D+/D-, decodes the line state and recovers a mid-bit sample strobe
// from a phase counter that realigns on every line transition.
module usb_bit_sampler
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usb_dp,
  input  logic        usb_dm,
  output logic        bit_stb,
  output line_state_t line_state,
  output line_state_t prev_line_state
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  logic [1:0]  dp_sync_r;
  logic [1:0]  dm_sync_r;
  line_state_t cur_ls_s;
  line_state_t last_ls_r;
  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_nxt_s;

  assign cur_ls_s = line_state_t'({dp_sync_r[1], dm_sync_r[1]});

  // Next phase: realign on a line transition, otherwise wrap at the bit length.
  always_comb begin
    phase_nxt_s = '0;
    if (cur_ls_s != last_ls_r) begin
      phase_nxt_s = '0;
    end else if (phase_r == PW'(CLKS_PER_BIT - 1)) begin
      phase_nxt_s = '0;
    end else begin
      phase_nxt_s = phase_r + PW'(1);
    end
  end

  // Synchronisers, phase tracking and mid-bit sampling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dp_sync_r       <= 2'b11;
      dm_sync_r       <= 2'b00;
      last_ls_r       <= LS_J;
      phase_r         <= '0;
      bit_stb         <= 1'b0;
      line_state      <= LS_J;
      prev_line_state <= LS_J;
    end else begin
      dp_sync_r <= {dp_sync_r[0], usb_dp};
      dm_sync_r <= {dm_sync_r[0], usb_dm};
      last_ls_r <= cur_ls_s;
      phase_r   <= phase_nxt_s;
      bit_stb   <= (phase_nxt_s == PW'(CLKS_PER_BIT / 2 - 1));
      if (phase_nxt_s == PW'(CLKS_PER_BIT / 2 - 1)) begin
        line_state      <= cur_ls_s;
        prev_line_state <= line_state;
      end
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive sequencer: NRZI decode, bit destuffing, SYNC/DATA/EOP framing, bus-reset
// detection and the byte handshake towards the device core.
module usb_rx_ctrl
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int RESET_BITS   = 16,
  parameter int SYNC_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_dp,
  input  logic       usb_dm,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       usb_en,
  output logic       pkt_end,
  output logic       bus_reset,
  output logic       rx_err,
  output logic [2:0] err_code
);

  localparam int SW = $clog2(RESET_BITS + 1);
  localparam int TW = $clog2(SYNC_TIMEOUT + 1);

  logic        bit_stb_s;
  line_state_t line_state_s;
  line_state_t prev_line_state_s;
  logic        nrzi_s;
  logic [7:0]  sync_next_s;
  logic [7:0]  byte_next_s;

  rx_state_t   state_r;
  logic [7:0]  sync_sr_r;
  logic [7:0]  data_sr_r;
  logic [TW-1:0] sync_cnt_r;
  logic [SW-1:0] se0_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [2:0]  ones_cnt_r;
  logic [1:0]  eop_cnt_r;
  logic        j_seen_r;

  usb_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .usb_dp          (usb_dp),
    .usb_dm          (usb_dm),
    .bit_stb         (bit_stb_s),
    .line_state      (line_state_s),
    .prev_line_state (prev_line_state_s)
  );

  assign nrzi_s      = nrzi_bit(line_state_s, prev_line_state_s);
  assign sync_next_s = {nrzi_s, sync_sr_r[7:1]};
  assign byte_next_s = {nrzi_s, data_sr_r[7:1]};

  // Sequencer and registered outputs; everything advances on the bit strobe except pulse/handshake clears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;   sync_sr_r <= 8'h00;  data_sr_r <= 8'h00;
      sync_cnt_r <= '0;     se0_cnt_r <= '0;     bit_cnt_r <= 3'd0;
      ones_cnt_r <= 3'd0;   eop_cnt_r <= 2'd0;   j_seen_r  <= 1'b0;
      rx_data <= 8'h00;     rx_valid <= 1'b0;    usb_en <= 1'b0;
      pkt_end <= 1'b0;      bus_reset <= 1'b0;   rx_err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      pkt_end   <= 1'b0;
      bus_reset <= 1'b0;
      rx_err    <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (bit_stb_s) begin
        if (line_state_s == LS_SE0) begin
          if (se0_cnt_r != SW'(RESET_BITS)) se0_cnt_r <= se0_cnt_r + SW'(1);
        end else begin
          se0_cnt_r <= '0;
        end
        j_seen_r <= 1'b0;
        if (line_state_s == LS_SE0 && se0_cnt_r == SW'(RESET_BITS - 1)) begin
          bus_reset <= 1'b1;
          state_r   <= ST_IDLE;
          rx_valid  <= 1'b0;
          usb_en    <= 1'b0;
        end else begin
          case (state_r)
            ST_IDLE: begin
              if (line_state_s == LS_K) begin
                state_r    <= ST_SYNC;
                sync_sr_r  <= 8'h7F;
                sync_cnt_r <= TW'(1);
              end
            end
            ST_SYNC: begin
              if (line_state_s == LS_SE1) begin
                state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_SE1;
              end else if (line_state_s != LS_SE0 && sync_next_s == SYNC_PATTERN) begin
                state_r    <= ST_DATA;
                usb_en     <= 1'b1;
                ones_cnt_r <= 3'd0;
                bit_cnt_r  <= 3'd0;
              end else if (sync_cnt_r >= TW'(SYNC_TIMEOUT - 1)) begin
                state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_SYNC_TIMEOUT;
              end else begin
                sync_cnt_r <= sync_cnt_r + TW'(1);
                if (line_state_s != LS_SE0) sync_sr_r <= sync_next_s;
              end
            end
            ST_DATA: begin
              if (line_state_s == LS_SE1) begin
                state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_SE1;
              end else if (line_state_s == LS_SE0) begin
                if (bit_cnt_r != 3'd0) begin
                  state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_ALIGN;
                end else begin
                  state_r   <= ST_EOP;
                  eop_cnt_r <= 2'd1;
                end
              end else if (ones_cnt_r == 3'd6) begin
                // Stuffed position: a 0 is discarded, a 1 is a stuffing violation.
                if (nrzi_s) begin
                  state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_STUFF;
                end else begin
                  ones_cnt_r <= 3'd0;
                end
              end else begin
                data_sr_r  <= byte_next_s;
                ones_cnt_r <= nrzi_s ? ones_cnt_r + 3'd1 : 3'd0;
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                  if (rx_valid && !rx_ready) begin
                    rx_err   <= 1'b1;
                    err_code <= ERR_OVERFLOW;
                  end else begin
                    rx_data  <= byte_next_s;
                    rx_valid <= 1'b1;
                  end
                end
              end
            end
            ST_EOP: begin
              if (line_state_s == LS_SE1) begin
                state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_SE1;
              end else if (line_state_s == LS_SE0) begin
                if (eop_cnt_r != 2'd3) eop_cnt_r <= eop_cnt_r + 2'd1;
              end else if (line_state_s == LS_J) begin
                state_r <= ST_IDLE;
                usb_en  <= 1'b0;
                if (eop_cnt_r <= 2'd2) pkt_end <= 1'b1;
              end else begin
                state_r <= ST_ERROR; usb_en <= 1'b0; rx_err <= 1'b1; err_code <= ERR_ALIGN;
              end
            end
            ST_ERROR: begin
              usb_en <= 1'b0;
              if (line_state_s == LS_J) begin
                if (j_seen_r) state_r <= ST_IDLE;
                else j_seen_r <= 1'b1;
              end
            end
            default: begin
              state_r <= ST_IDLE;
              usb_en  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_usb_rx_ctrl;

  localparam int CPB    = 4;
  localparam int K_BYTE = 0;
  localparam int K_END  = 1;
  localparam int K_ERR  = 2;
  localparam int K_BRST = 3;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       usb_dp;
  logic       usb_dm;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       usb_en;
  logic       pkt_end;
  logic       bus_reset;
  logic       rx_err;
  logic [2:0] err_code;

  int         tests = 0;
  int         fails = 0;
  int         exp_kind[$];
  int         exp_val[$];
  logic [1:0] cur;
  int         ones;
  logic       valid_q = 1'b0;

  always #5 clk = ~clk;

  usb_rx_ctrl #(.CLKS_PER_BIT(CPB), .RESET_BITS(16), .SYNC_TIMEOUT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .usb_dp    (usb_dp),
    .usb_dm    (usb_dm),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .usb_en    (usb_en),
    .pkt_end   (pkt_end),
    .bus_reset (bus_reset),
    .rx_err    (rx_err),
    .err_code  (err_code)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int k, input int v);
    exp_kind.push_back(k);
    exp_val.push_back(v);
  endtask

  task automatic pop_check(input string name, input int k, input int v);
    int ek;
    int ev;
    if (exp_kind.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: unexpected event kind %0d value 0x%0h", name, k, v);
    end else begin
      ek = exp_kind.pop_front();
      ev = exp_val.pop_front();
      check(name, k * 256 + v, ek * 256 + ev);
    end
  endtask

  // Monitor: every presented event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_reset) pop_check("bus_reset", K_BRST, 0);
      if (rx_err) pop_check("rx_err", K_ERR, int'(err_code));
      if (rx_valid && !valid_q) pop_check("rx_byte", K_BYTE, int'(rx_data));
      if (pkt_end) pop_check("pkt_end", K_END, 0);
    end
    valid_q <= rx_valid;
  end

  task automatic drive(input logic [1:0] ls, input int nbits);
    usb_dp = ls[1];
    usb_dm = ls[0];
    repeat (CPB * nbits) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur = ~cur;
    drive(cur, 1);
  endtask

  task automatic send_sync();
    cur = LJ;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      ones = d[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    drive(LSE0, 2);
    cur = LJ;
    drive(LJ, 3);
  endtask

  initial begin
    rst = 1'b0; rx_ready = 1'b1; usb_dp = 1'b1; usb_dm = 1'b0; cur = LJ; ones = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({rx_data, rx_valid, usb_en, pkt_end, bus_reset, rx_err, err_code}), 0);
    rst = 1'b1;
    drive(LJ, 4);

    // Single byte packet
    expect_ev(K_BYTE, 8'hA5); expect_ev(K_END, 0);
    send_sync(); send_byte(8'hA5);
    check("usb_en_in_packet", int'(usb_en), 1);
    send_eop();
    check("usb_en_after_eop", int'(usb_en), 0);
    drive(LJ, 2);

    // Bit stuffing across 0xFF 0x01
    expect_ev(K_BYTE, 8'hFF); expect_ev(K_BYTE, 8'h01); expect_ev(K_END, 0);
    send_sync(); send_byte(8'hFF); send_byte(8'h01); send_eop();
    drive(LJ, 2);

    // Seven ones with no stuff bit
    expect_ev(K_ERR, 2);
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    cur = LJ;
    drive(LJ, 4);
    check("usb_en_after_stuff_err", int'(usb_en), 0);
    check("err_code_held", int'(err_code), 2);

    // Overflow with rx_ready low
    rx_ready = 1'b0;
    expect_ev(K_BYTE, 8'h3C); expect_ev(K_ERR, 4); expect_ev(K_END, 0);
    send_sync(); send_byte(8'h3C); send_byte(8'hC3); send_eop();
    check("overflow_data_kept", int'(rx_data), 8'h3C);
    check("overflow_valid_held", int'(rx_valid), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("valid_cleared_on_handshake", int'(rx_valid), 0);
    drive(LJ, 2);

    // Bus reset after a byte, with the byte still pending
    rx_ready = 1'b0;
    expect_ev(K_BYTE, 8'h5A); expect_ev(K_BRST, 0);
    send_sync(); send_byte(8'h5A);
    drive(LSE0, 20);
    check("bus_reset_usb_en", int'(usb_en), 0);
    check("bus_reset_rx_valid", int'(rx_valid), 0);
    cur = LJ;
    drive(LJ, 4);
    rx_ready = 1'b1;

    // Reset mid-byte, then a clean packet
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b0; usb_dp = 1'b1; usb_dm = 1'b0;
    @(negedge clk);
    check("mid_packet_reset", int'({rx_data, rx_valid, usb_en, pkt_end, bus_reset, rx_err, err_code}), 0);
    rst = 1'b1;
    cur = LJ;
    drive(LJ, 4);
    expect_ev(K_BYTE, 8'h96); expect_ev(K_END, 0);
    send_sync(); send_byte(8'h96); send_eop();
    drive(LJ, 4);

    check("events_outstanding", exp_kind.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
